// File: rtl/io_port.sv
// io_port -- memory-mapped I/O port with an 11-bit input, a FIFO-buffered
// 11-bit output, and a drain FSM that paces output updates.
//
// Word map (address[1:0]):
//   0 IN     : synchronized io_input_bus, zero-extended (read only)
//   1 STATUS : {25'b0, count[3:0], empty, full, changed} (read clears changed)
//   2 OUT    : write pushes write_data[10:0]; read returns last pushed value
//   3 HOLD   : write loads hold[15:0]; read returns hold, zero-extended
//
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   address, write_data : MEM-stage address / store data
//   wren, rden          : one-cycle store / load strobes (both high = ignored)
//   read_data           : load data, registered (data-memory latency)
//   stale               : combinational stall request (OUT store while full)
//   io_input_bus        : asynchronous external inputs
//   io_output_bus       : registered external outputs
//
// Configuration macro:
//   IO_PORT_INPUT_SYNC_EN defined   -> 2-flop input synchronizer
//   IO_PORT_INPUT_SYNC_EN undefined -> single input register stage
//
// Drain pacing: each popped word is held for hold+1 cycles in HOLDING,
// so consecutive words leave every hold+2 cycles.

module io_port #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] HOLD_RESET = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic [31:0] write_data,
  input  logic        wren,
  input  logic        rden,
  output logic [31:0] read_data,
  output logic        stale,
  input  logic [10:0] io_input_bus,
  output logic [10:0] io_output_bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

`ifdef IO_PORT_INPUT_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 1;
`endif

  localparam logic [1:0] ADDR_IN     = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_OUT    = 2'd2;
  localparam logic [1:0] ADDR_HOLD   = 2'd3;

  typedef enum logic {S_IDLE, S_HOLDING} state_e;

  // input synchronizer chain; last stage is the "synchronized input"
  logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
  logic [10:0]                  prev_q, prev_d;
  logic [10:0]                  in_sync;
  logic                         changed_q, changed_d;

  // output FIFO
  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [10:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [10:0]   last_out_q, last_out_d;

  // drain FSM
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [10:0] out_q, out_d;

  logic [31:0] rdata_q, rdata_d;

  logic       wr_acc, rd_acc;
  logic       full, empty;
  logic       push, pop;
  logic       status_rd, detect;
  logic [4:0] count_w;
  logic       wdata_unused;

  // simultaneous strobes are treated as no access at all
  assign wr_acc = wren & ~rden;
  assign rd_acc = rden & ~wren;

  // full/empty come from the registered count only, so a pop in the
  // current cycle never releases a stall in the same cycle
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  assign stale = wren && (address == ADDR_OUT) && full;
  assign push  = wr_acc && (address == ADDR_OUT) && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign status_rd = rd_acc && (address == ADDR_STATUS);
  assign detect    = (in_sync != prev_q);
  assign count_w   = 5'(count_q);

  assign wdata_unused = ^{write_data[31:16], count_w[4]};

  // ---------------------------------------------------------------
  // input synchronizer and change detection
  // ---------------------------------------------------------------
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = io_input_bus;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = in_sync;
    // a fresh change wins over the clear from a STATUS read
    changed_d = detect | (changed_q & ~status_rd);
  end

  // ---------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------
  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    last_out_d = last_out_q;
    if (push) begin
      mem_d[wptr_q] = write_data[10:0];
      wptr_d        = wptr_q + PW'(1);
      last_out_d    = write_data[10:0];
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------
  // drain FSM and hold register
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    hold_d  = hold_q;
    // a new hold value only matters at the next load; cnt_q keeps running
    if (wr_acc && (address == ADDR_HOLD)) begin
      hold_d = write_data[15:0];
    end
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          out_d   = mem_q[rptr_q];
          cnt_d   = hold_q;
          state_d = S_HOLDING;
        end
      end
      S_HOLDING: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // load data path
  // ---------------------------------------------------------------
  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) begin
      case (address)
        ADDR_IN:     rdata_d = {21'b0, in_sync};
        ADDR_STATUS: rdata_d = {25'b0, count_w[3:0], empty, full, changed_q};
        ADDR_OUT:    rdata_d = {21'b0, last_out_q};
        ADDR_HOLD:   rdata_d = {16'b0, hold_q};
        default:     rdata_d = rdata_q;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // state registers
  // ---------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= '0;
      changed_q  <= 1'b0;
      mem_q      <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      last_out_q <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hold_q     <= HOLD_RESET;
      out_q      <= '0;
      rdata_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      changed_q  <= changed_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      last_out_q <= last_out_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      out_q      <= out_d;
      rdata_q    <= rdata_d;
    end
  end

  assign read_data     = rdata_q;
  assign io_output_bus = out_q;

endmodule

// File: tb/tb_io_port.sv
// tb_io_port -- randomized + directed bench for io_port against a
// transaction-level model (queue FIFO, time-stamped pacing, input history).

module tb_io_port;

  localparam int DEPTH = 4;
`ifdef IO_PORT_INPUT_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif

  logic        clock;
  logic        reset;
  logic [1:0]  address;
  logic [31:0] write_data;
  logic        wren;
  logic        rden;
  logic [31:0] read_data;
  logic        stale;
  logic [10:0] io_input_bus;
  logic [10:0] io_output_bus;

  io_port #(.FIFO_DEPTH(DEPTH), .HOLD_RESET(16'h0000)) dut (
    .clock(clock), .reset(reset), .address(address), .write_data(write_data),
    .wren(wren), .rden(rden), .read_data(read_data), .stale(stale),
    .io_input_bus(io_input_bus), .io_output_bus(io_output_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // model state
  logic [10:0] q[$];
  logic [10:0] hist[$];
  logic [15:0] m_hold = 16'h0;
  logic [10:0] m_out  = 11'h0;
  logic [10:0] m_last = 11'h0;
  logic [10:0] m_prev = 11'h0;
  logic        m_chg  = 1'b0;
  logic [31:0] m_rd   = 32'h0;
  int          next_pop = 0;
  int          cyc = 0;

  // observation helpers
  logic        last_stale;
  logic [10:0] last_obs;
  int          chg_t[$];
  logic [10:0] chg_v[$];
  logic [10:0] cur_in = 11'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one clock of stimulus; model advances on the edge, outputs checked after
  task automatic step(input logic [1:0] a, input logic [31:0] d, input logic w,
                      input logic r, input logic [10:0] inb, input logic rs);
    logic [10:0] sy;
    logic        det, full_m, st_rd;
    logic [4:0]  cn;
    address = a; write_data = d; wren = w; rden = r; io_input_bus = inb; reset = rs;
    #1;
    chk("stale", {31'b0, stale}, {31'b0, (w && a == 2'd2 && q.size() == DEPTH)});
    last_stale = stale;
    @(posedge clock);
    cyc++;
    if (rs) begin
      q.delete();
      hist.delete();
      repeat (SYNC) hist.push_back(11'h0);
      m_hold = 16'h0; m_out = '0; m_last = '0; m_prev = '0; m_chg = 1'b0; m_rd = '0;
      next_pop = cyc + 1;
    end else begin
      sy     = hist[0];
      det    = (sy != m_prev);
      st_rd  = r && !w && a == 2'd1;
      full_m = (q.size() == DEPTH);
      cn     = 5'(q.size());
      if (r && !w) begin
        case (a)
          2'd0:    m_rd = {21'b0, sy};
          2'd1:    m_rd = {25'b0, cn[3:0], q.size() == 0, full_m, m_chg};
          2'd2:    m_rd = {21'b0, m_last};
          default: m_rd = {16'b0, m_hold};
        endcase
      end
      m_chg  = det || (m_chg && !st_rd);
      m_prev = sy;
      void'(hist.pop_front());
      hist.push_back(inb);
      if (cyc >= next_pop && q.size() > 0) begin
        m_out    = q.pop_front();
        next_pop = cyc + int'(m_hold) + 2;
      end
      if (w && !r && a == 2'd2 && !full_m) begin
        q.push_back(d[10:0]);
        m_last = d[10:0];
      end
      if (w && !r && a == 2'd3) m_hold = d[15:0];
    end
    @(negedge clock);
    chk("rdata", read_data, m_rd);
    chk("out", {21'b0, io_output_bus}, {21'b0, m_out});
    if (io_output_bus !== last_obs) begin
      chg_t.push_back(cyc);
      chg_v.push_back(io_output_bus);
      last_obs = io_output_bus;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'd0, 32'h0, 1'b0, 1'b0, cur_in, 1'b0);
  endtask

  initial begin
    logic [10:0] vals[6];
    int          n, stalls, lat;
    logic [1:0]  a;
    logic [31:0] d;
    logic        w, r, rs;

    repeat (SYNC) hist.push_back(11'h0);

    // reset and reset-state STATUS
    step(2'd0, 32'h0, 1'b0, 1'b0, cur_in, 1'b1);
    step(2'd0, 32'h0, 1'b0, 1'b0, cur_in, 1'b1);
    step(2'd1, 32'h0, 1'b0, 1'b1, cur_in, 1'b0);
    chk("rst_status", read_data, 32'h4);
    chk("rst_out", {21'b0, io_output_bus}, 32'h0);

    // hold=0: back-to-back pushes drain every 2 cycles
    step(2'd2, 32'h155, 1'b1, 1'b0, cur_in, 1'b0);
    step(2'd2, 32'h2AA, 1'b1, 1'b0, cur_in, 1'b0);
    chk("p1_out", {21'b0, io_output_bus}, 32'h155);
    idle(1);
    chk("p1_hold", {21'b0, io_output_bus}, 32'h155);
    idle(1);
    chk("p2_out", {21'b0, io_output_bus}, 32'h2AA);
    idle(3);

    // hold=5: fill, stall on full, 7-cycle spacing, order preserved
    step(2'd3, 32'h5, 1'b1, 1'b0, cur_in, 1'b0);
    vals = '{11'h101, 11'h202, 11'h303, 11'h104, 11'h205, 11'h306};
    chg_t.delete(); chg_v.delete();
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      do begin
        step(2'd2, {21'b0, vals[i]}, 1'b1, 1'b0, cur_in, 1'b0);
        n++;
        if (last_stale) stalls++;
      end while (last_stale && n < 60);
      chk("stall_bound", 32'(n < 60), 32'h1);
    end
    idle(50);
    chk("stall_seen", 32'(stalls > 0), 32'h1);
    chk("n_pops", chg_t.size(), 6);
    for (int i = 0; i < chg_v.size() && i < 6; i++) begin
      chk("pop_val", {21'b0, chg_v[i]}, {21'b0, vals[i]});
      if (i > 0) chk("spacing", chg_t[i] - chg_t[i-1], 7);
    end
    step(2'd3, 32'h0, 1'b1, 1'b0, cur_in, 1'b0);
    idle(3);

    // input latency and changed flag
    cur_in = 11'h000;
    idle(4);
    step(2'd1, 32'h0, 1'b0, 1'b1, cur_in, 1'b0);
    cur_in = 11'h7FF;
    lat = 0;
    do begin
      step(2'd0, 32'h0, 1'b0, 1'b1, cur_in, 1'b0);
      lat++;
    end while (read_data != 32'h7FF && lat < 10);
    chk("in_lat", lat, SYNC + 1);
    step(2'd1, 32'h0, 1'b0, 1'b1, cur_in, 1'b0);
    chk("chg_set", {31'b0, read_data[0]}, 32'h1);
    step(2'd1, 32'h0, 1'b0, 1'b1, cur_in, 1'b0);
    chk("chg_clr", {31'b0, read_data[0]}, 32'h0);

    // change detected in the same cycle as a STATUS read keeps changed
    cur_in = 11'h000;
    for (int j = 0; j <= SYNC + 1; j++) begin
      step(2'd1, 32'h0, 1'b0, 1'b1, cur_in, 1'b0);
      if (j == SYNC) chk("chg_pre", {31'b0, read_data[0]}, 32'h0);
    end
    chk("chg_keep", {31'b0, read_data[0]}, 32'h1);

    // both strobes: ignored
    step(2'd2, 32'h3FF, 1'b1, 1'b1, cur_in, 1'b0);
    idle(3);

    // reset during HOLDING with entries queued
    idle(4);
    step(2'd3, 32'h5, 1'b1, 1'b0, cur_in, 1'b0);
    step(2'd2, 32'h011, 1'b1, 1'b0, cur_in, 1'b0);
    step(2'd2, 32'h022, 1'b1, 1'b0, cur_in, 1'b0);
    step(2'd2, 32'h033, 1'b1, 1'b0, cur_in, 1'b0);
    step(2'd2, 32'h044, 1'b1, 1'b0, cur_in, 1'b0);
    step(2'd2, 32'h555, 1'b1, 1'b0, cur_in, 1'b1);
    chk("rst2_out", {21'b0, io_output_bus}, 32'h0);
    chg_t.delete(); chg_v.delete();
    step(2'd1, 32'h0, 1'b0, 1'b1, cur_in, 1'b0);
    chk("rst2_status", read_data, 32'h4);
    idle(20);
    chk("rst2_quiet", chg_t.size(), 0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      a = 2'($urandom_range(0, 3));
      w = ($urandom % 3) == 0;
      r = ($urandom % 4) == 0;
      d = $urandom;
      if (a == 2'd3) d[15:0] = 16'($urandom_range(0, 3));
      if (($urandom % 8) == 0) cur_in = 11'($urandom);
      rs = ($urandom % 150) == 0;
      step(a, d, w, r, cur_in, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
